cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single ROB result-write port between the two execute ends: the ALU reservation station and the load/store buffer.
- Each source gets a small FIFO; a round-robin arbiter picks one result per cycle and drives it on a registered common data bus (CDB).
- The CDB feeds the ROB set port and the RS/LSB operand wake-up logic.
- A mispredict clear from the ROB flushes all in-flight results.

Parameters:
- ROB_WIDTH_BIT, 5, width of ROB entry index.
- DATA_WIDTH, 32, result value width.
- FIFO_DEPTH_BIT, 1, log2 of per-source FIFO depth (default depth 2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global ready; block fully frozen when low.
- clear_in  input  1  ROB mispredict clear; flushes block.
- alu_valid  input  1  ALU result offered this cycle.
- alu_rob_id  input  ROB_WIDTH_BIT  target ROB entry.
- alu_val  input  DATA_WIDTH  ALU result.
- alu_ready  output  1  ALU FIFO can accept this cycle.
- lsb_valid  input  1  LSB completion offered.
- lsb_has_val  input  1  1 = load with value; 0 = store (mark ready only).
- lsb_rob_id  input  ROB_WIDTH_BIT  target ROB entry.
- lsb_val  input  DATA_WIDTH  load data (don't-care when lsb_has_val=0).
- lsb_ready  output  1  LSB FIFO can accept this cycle.
- cdb_valid  output  1  bus carries a result this cycle.
- cdb_src  output  1  0 = ALU, 1 = LSB.
- cdb_has_val  output  1  value field meaningful (1 for every ALU entry).
- cdb_rob_id  output  ROB_WIDTH_BIT  ROB entry to set ready.
- cdb_val  output  DATA_WIDTH  result value.
- conflict_cnt  output  32  cycles in which both sources had a candidate.

Behaviour:
- Reset (async, rst_in=1): FIFOs empty; all cdb_* = 0; conflict_cnt = 0; last_grant = 1 (LSB), so the ALU wins the first tie. Reset takes effect immediately mid-operation.
- xx_ready = rdy_in && !clear_in && (count_xx != DEPTH). Combinational. Stays conservative: it is low when full, even if the head is granted in the same cycle.
- An offer is accepted only when xx_valid && xx_ready at a rising edge. An offer that is not accepted is not stored; the source must hold it.
- Candidate per source = FIFO head if the FIFO is non-empty, else the accepted incoming offer (bypass), else none.
- Grant, evaluated at each edge with rdy_in=1 and clear_in=0:
  - One candidate: grant it.
  - Both: grant the source != last_grant, update last_grant, and conflict_cnt += 1 (wraps modulo 2^32).
  - None: cdb_valid <= 0.
- Granted candidate is loaded into the cdb_* registers. cdb_valid is high for exactly one cycle per granted entry.
- Granted FIFO head is popped. A granted bypass offer is never written to the FIFO. An accepted but non-granted offer is pushed to the tail.
- Push and pop on the same source in one edge: count unchanged, order preserved.
- Latency: an offer accepted at edge N into an empty FIFO, and granted, is on the CDB during the cycle after edge N. Each queued entry adds at least one cycle.
- Per-source order is strict FIFO. Pointers wrap modulo DEPTH.
- clear_in && rdy_in at an edge:
  - Both FIFOs emptied, cdb_valid <= 0, incoming offers discarded, last_grant <= 1.
  - conflict_cnt is kept.
  - clear_in takes priority over grants in the same edge.
- rdy_in=0: all state frozen, cdb_* hold their values, xx_ready = 0, offers ignored.
- cdb_has_val <= 1 for ALU grants, lsb_has_val for LSB grants.

Test Plan:
- Reset, then ALU offers id=3, val=0x11 alone → next cycle cdb_valid=1, src=0, rob_id=3, val=0x11, has_val=1; the cycle after, cdb_valid=0.
- ALU (id=1) and LSB (id=2, has_val=1, val=0xAA) offered the same edge after reset → ALU on CDB first, LSB next cycle; conflict_cnt=1.
- LSB store (has_val=0, id=7) offered while idle → cdb_src=1, cdb_has_val=0, rob_id=7.
- Both sources offer every cycle for 6 cycles:
  - alu_ready and lsb_ready fall to 0 once their FIFOs reach 2 entries.
  - CDB alternates strictly ALU/LSB.
  - No entry is lost; per-source order matches the offer order.
- Fill both FIFOs, assert clear_in for one cycle → next cycle cdb_valid=0 and both ready=1; no pre-clear entry ever appears on the CDB; conflict_cnt unchanged.
- Hold rdy_in=0 for 3 cycles with a result on the CDB and offers pending → cdb_* unchanged and ready=0; arbitration resumes on the first rdy_in=1 edge.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result-bus interface for the CDB arbiter.
// Carries the two execute-side result offers (ALU, LSB) with their ready
// back-pressure, and the registered common data bus that leaves the arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH_BIT = 5,
    parameter int DATA_WIDTH    = 32
);
    // ALU reservation-station result offer
    logic                     alu_valid;
    logic [ROB_WIDTH_BIT-1:0] alu_rob_id;
    logic [DATA_WIDTH-1:0]    alu_val;
    logic                     alu_ready;

    // Load/store-buffer completion offer
    logic                     lsb_valid;
    logic                     lsb_has_val;
    logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
    logic [DATA_WIDTH-1:0]    lsb_val;
    logic                     lsb_ready;

    // Common data bus toward ROB set port and operand wake-up
    logic                     cdb_valid;
    logic                     cdb_src;
    logic                     cdb_has_val;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
    logic [DATA_WIDTH-1:0]    cdb_val;

    // Execute units and bus consumers
    modport master (
        output alu_valid, alu_rob_id, alu_val,
        input  alu_ready,
        output lsb_valid, lsb_has_val, lsb_rob_id, lsb_val,
        input  lsb_ready,
        input  cdb_valid, cdb_src, cdb_has_val, cdb_rob_id, cdb_val
    );

    // The arbiter itself
    modport slave (
        input  alu_valid, alu_rob_id, alu_val,
        output alu_ready,
        input  lsb_valid, lsb_has_val, lsb_rob_id, lsb_val,
        output lsb_ready,
        output cdb_valid, cdb_src, cdb_has_val, cdb_rob_id, cdb_val
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one small FIFO per execute source, a round-robin pick of one
// result per cycle, and a registered common data bus. A candidate is either
// the FIFO head or, when the FIFO is empty, the offer accepted this edge
// (bypass), so an idle path costs a single cycle of latency.
module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT  = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    cdb_arbiter_if.slave bus,
    output logic [31:0] conflict_cnt
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam int CNT_W = FIFO_DEPTH_BIT + 1;

    typedef logic [CNT_W-1:0]          cnt_t;
    typedef logic [FIFO_DEPTH_BIT-1:0] ptr_t;

    // FIFO storage (no reset: validity is tracked by the counters)
    logic [ROB_WIDTH_BIT-1:0] r_alu_id   [DEPTH];
    logic [DATA_WIDTH-1:0]    r_alu_data [DEPTH];
    logic [ROB_WIDTH_BIT-1:0] r_lsb_id   [DEPTH];
    logic [DATA_WIDTH-1:0]    r_lsb_data [DEPTH];
    logic                     r_lsb_hv   [DEPTH];

    // FIFO control
    cnt_t r_alu_cnt, r_lsb_cnt;
    ptr_t r_alu_rp, r_alu_wp, r_lsb_rp, r_lsb_wp;
    logic r_last_grant;   // 0 = ALU granted last tie, 1 = LSB
    logic [31:0] r_conflict_cnt;

    // Bus registers
    logic                     r_cdb_valid;
    logic                     r_cdb_src;
    logic                     r_cdb_has_val;
    logic [ROB_WIDTH_BIT-1:0] r_cdb_rob_id;
    logic [DATA_WIDTH-1:0]    r_cdb_val;

    // Combinational arbitration signals
    logic                     w_alu_nonempty, w_lsb_nonempty;
    logic                     w_alu_acc, w_lsb_acc;
    logic                     w_alu_cand, w_lsb_cand;
    logic                     w_both;
    logic                     w_gnt_alu, w_gnt_lsb;
    logic                     w_alu_push, w_alu_pop, w_lsb_push, w_lsb_pop;
    logic [ROB_WIDTH_BIT-1:0] w_alu_c_id, w_lsb_c_id;
    logic [DATA_WIDTH-1:0]    w_alu_c_val, w_lsb_c_val;
    logic                     w_lsb_c_hv;
    logic                     w_active;

    // Ready is conservative: a full FIFO refuses even if its head leaves now
    assign bus.alu_ready = rdy_in && !clear_in && (r_alu_cnt != cnt_t'(DEPTH));
    assign bus.lsb_ready = rdy_in && !clear_in && (r_lsb_cnt != cnt_t'(DEPTH));

    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_src     = r_cdb_src;
    assign bus.cdb_has_val = r_cdb_has_val;
    assign bus.cdb_rob_id  = r_cdb_rob_id;
    assign bus.cdb_val     = r_cdb_val;
    assign conflict_cnt    = r_conflict_cnt;

    assign w_active = rdy_in && !clear_in;

    // Candidate selection, round-robin grant and FIFO push/pop decisions
    always_comb begin
        w_alu_nonempty = (r_alu_cnt != '0);
        w_lsb_nonempty = (r_lsb_cnt != '0);
        w_alu_acc      = bus.alu_valid && bus.alu_ready;
        w_lsb_acc      = bus.lsb_valid && bus.lsb_ready;
        w_alu_cand     = w_alu_nonempty || w_alu_acc;
        w_lsb_cand     = w_lsb_nonempty || w_lsb_acc;

        w_alu_c_id  = w_alu_nonempty ? r_alu_id[r_alu_rp]   : bus.alu_rob_id;
        w_alu_c_val = w_alu_nonempty ? r_alu_data[r_alu_rp] : bus.alu_val;
        w_lsb_c_id  = w_lsb_nonempty ? r_lsb_id[r_lsb_rp]   : bus.lsb_rob_id;
        w_lsb_c_val = w_lsb_nonempty ? r_lsb_data[r_lsb_rp] : bus.lsb_val;
        w_lsb_c_hv  = w_lsb_nonempty ? r_lsb_hv[r_lsb_rp]   : bus.lsb_has_val;

        // On a tie the source that did not win the previous tie goes first
        w_both    = w_alu_cand && w_lsb_cand;
        w_gnt_alu = w_alu_cand && (!w_lsb_cand || r_last_grant);
        w_gnt_lsb = w_lsb_cand && !w_gnt_alu;

        // A granted bypass offer never enters its FIFO
        w_alu_pop  = w_gnt_alu && w_alu_nonempty;
        w_lsb_pop  = w_gnt_lsb && w_lsb_nonempty;
        w_alu_push = w_alu_acc && !(w_gnt_alu && !w_alu_nonempty);
        w_lsb_push = w_lsb_acc && !(w_gnt_lsb && !w_lsb_nonempty);
    end

    // Control state and bus registers: reset, clear flush, frozen, or arbitrate
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_alu_cnt      <= '0;
            r_lsb_cnt      <= '0;
            r_alu_rp       <= '0;
            r_alu_wp       <= '0;
            r_lsb_rp       <= '0;
            r_lsb_wp       <= '0;
            r_last_grant   <= 1'b1;
            r_conflict_cnt <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_src      <= 1'b0;
            r_cdb_has_val  <= 1'b0;
            r_cdb_rob_id   <= '0;
            r_cdb_val      <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_alu_cnt    <= '0;
                r_lsb_cnt    <= '0;
                r_alu_rp     <= '0;
                r_alu_wp     <= '0;
                r_lsb_rp     <= '0;
                r_lsb_wp     <= '0;
                r_last_grant <= 1'b1;
                r_cdb_valid  <= 1'b0;
            end else begin
                r_cdb_valid <= w_gnt_alu || w_gnt_lsb;
                if (w_gnt_alu) begin
                    r_cdb_src     <= 1'b0;
                    r_cdb_has_val <= 1'b1;
                    r_cdb_rob_id  <= w_alu_c_id;
                    r_cdb_val     <= w_alu_c_val;
                end else if (w_gnt_lsb) begin
                    r_cdb_src     <= 1'b1;
                    r_cdb_has_val <= w_lsb_c_hv;
                    r_cdb_rob_id  <= w_lsb_c_id;
                    r_cdb_val     <= w_lsb_c_val;
                end
                if (w_both) begin
                    r_last_grant   <= w_gnt_lsb;
                    r_conflict_cnt <= r_conflict_cnt + 32'd1;
                end
                r_alu_cnt <= r_alu_cnt + cnt_t'(w_alu_push) - cnt_t'(w_alu_pop);
                r_lsb_cnt <= r_lsb_cnt + cnt_t'(w_lsb_push) - cnt_t'(w_lsb_pop);
                if (w_alu_push) r_alu_wp <= r_alu_wp + ptr_t'(1);
                if (w_alu_pop)  r_alu_rp <= r_alu_rp + ptr_t'(1);
                if (w_lsb_push) r_lsb_wp <= r_lsb_wp + ptr_t'(1);
                if (w_lsb_pop)  r_lsb_rp <= r_lsb_rp + ptr_t'(1);
            end
        end
    end

    // FIFO payload writes at the tail for accepted, non-bypassed offers
    always_ff @(posedge clk_in) begin
        if (w_active && w_alu_push) begin
            r_alu_id[r_alu_wp]   <= bus.alu_rob_id;
            r_alu_data[r_alu_wp] <= bus.alu_val;
        end
        if (w_active && w_lsb_push) begin
            r_lsb_id[r_lsb_wp]   <= bus.lsb_rob_id;
            r_lsb_data[r_lsb_wp] <= bus.lsb_val;
            r_lsb_hv[r_lsb_wp]   <= bus.lsb_has_val;
        end
    end
endmodule
